// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions: rounding modes, status bit
// positions, special encodings and the iterative divider state set.
package fp_pkg;

  localparam logic [2:0] RND_NEAR    = 3'd0;
  localparam logic [2:0] RND_ZERO    = 3'd1;
  localparam logic [2:0] RND_PINF    = 3'd2;
  localparam logic [2:0] RND_NINF    = 3'd3;
  localparam logic [2:0] RND_NEAR_UP = 3'd4;
  localparam logic [2:0] RND_AWAY    = 3'd5;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;
  localparam int ST_DIVZ    = 6;

  localparam int          BIAS       = 127;
  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_NORMAL = 32'h7F7F_FFFF;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, PREP, DIV, RND} state_t;

endpackage

// File: rtl/fp_div_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, MSB first.
// The dividend must already be pre-normalised so the quotient lies in [1,2).
module fp_div_core
  import fp_pkg::*;
#(
  parameter int QBITS = 25
) (
  input  logic             clk,
  input  logic             load,
  input  logic [24:0]      dividend,
  input  logic [23:0]      divisor,
  output logic [QBITS-1:0] quotient,
  output logic             sticky
);

  logic [24:0] rem_p0;
  logic [23:0] dvs_p0;
  logic        ge;
  logic [24:0] rem_sel;

  // Trial subtraction; the remainder is kept only when it does not go negative.
  always_comb begin
    ge      = (rem_p0 >= {1'b0, dvs_p0});
    rem_sel = ge ? (rem_p0 - {1'b0, dvs_p0}) : rem_p0;
  end

  // Iteration register: load operands, then shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_p0   <= dividend;
      dvs_p0   <= divisor;
      quotient <= '0;
    end else begin
      rem_p0   <= rem_sel << 1;
      quotient <= {quotient[QBITS-2:0], ge};
    end
  end

  // A shifted remainder is non-zero exactly when the true remainder is.
  assign sticky = |rem_p0;

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider z = a / b behind a
// start/busy/done handshake; fixed 27-cycle latency from accepted start.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [7:0]  status
);

  function automatic logic round_up(input logic [2:0] mode, input logic sgn,
                                    input logic l, input logic g, input logic s);
    case (mode)
      RND_NEAR:    round_up = g & (l | s);
      RND_ZERO:    round_up = 1'b0;
      RND_PINF:    round_up = (g | s) & ~sgn;
      RND_NINF:    round_up = (g | s) & sgn;
      RND_NEAR_UP: round_up = g;
      RND_AWAY:    round_up = g | s;
      default:     round_up = g & (l | s);
    endcase
  endfunction

  function automatic logic [31:0] ovf_result(input logic [2:0] mode, input logic sgn);
    logic to_inf;
    case (mode)
      RND_ZERO: to_inf = 1'b0;
      RND_PINF: to_inf = ~sgn;
      RND_NINF: to_inf = sgn;
      default:  to_inf = 1'b1;
    endcase
    ovf_result = to_inf ? {sgn, POS_INF[30:0]} : {sgn, MAX_NORMAL[30:0]};
  endfunction

  state_t state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic       accept, load, fin;

  logic [31:0] a_p0, b_p0;
  logic [2:0]  rnd_p0;

  logic               sgn;
  logic signed [9:0]  exp_pre, exp_adj;
  logic [24:0]        dividend;
  logic [23:0]        divisor;
  logic               spec;
  logic [31:0]        spec_z;
  logic [7:0]         spec_st;

  logic               sgn_p1;
  logic signed [9:0]  exp_p1;
  logic               spec_p1;
  logic [31:0]        spec_z_p1;
  logic [7:0]         spec_st_p1;

  logic [QBITS-1:0]   quot;
  logic               sticky;

  logic [24:0]        mant_r;
  logic signed [9:0]  exp_r;
  logic               up, inexact;
  logic [31:0]        z_nx;
  logic [7:0]         st_nx;

  fp_div_core #(.QBITS(QBITS)) u_core (
    .clk      (clk),
    .load     (load),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quot),
    .sticky   (sticky)
  );

  // Control: state, iteration counter and the registered result/handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      z      <= '0;
      status <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= fin;
      if (fin) begin
        z      <= z_nx;
        status <= st_nx;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    load     = 1'b0;
    fin      = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = PREP;
        end
      end
      PREP: begin
        load     = 1'b1;
        cnt_nx   = '0;
        state_nx = DIV;
      end
      DIV: begin
        busy   = 1'b1;
        cnt_nx = cnt + 5'd1;
        if (cnt == 5'(QBITS - 1)) state_nx = RND;
      end
      RND: begin
        busy     = 1'b1;
        fin      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- stage p0: operand capture on accepted start ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= a;
      b_p0   <= b;
      rnd_p0 <= rnd;
    end
  end

  // Unpack, classify (denormals flush to zero) and pre-normalise the dividend.
  always_comb begin
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    ea      = a_p0[30:23];
    eb      = b_p0[30:23];
    ma      = {1'b1, a_p0[22:0]};
    mb      = {1'b1, b_p0[22:0]};
    a_zero  = (ea == 8'd0);
    b_zero  = (eb == 8'd0);
    a_inf   = (ea == 8'hFF) && (a_p0[22:0] == 23'd0);
    b_inf   = (eb == 8'hFF) && (b_p0[22:0] == 23'd0);
    a_nan   = (ea == 8'hFF) && (a_p0[22:0] != 23'd0);
    b_nan   = (eb == 8'hFF) && (b_p0[22:0] != 23'd0);
    sgn     = a_p0[31] ^ b_p0[31];
    exp_pre = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS));
    divisor = mb;
    if (ma < mb) begin
      dividend = {ma, 1'b0};
      exp_adj  = exp_pre - 10'sd1;
    end else begin
      dividend = {1'b0, ma};
      exp_adj  = exp_pre;
    end
    spec    = 1'b1;
    spec_z  = '0;
    spec_st = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z          = CANON_NAN;
      spec_st[ST_NAN] = 1'b1;
    end else if (a_inf) begin
      spec_z          = {sgn, POS_INF[30:0]};
      spec_st[ST_INF] = 1'b1;
    end else if (b_zero) begin
      spec_z           = {sgn, POS_INF[30:0]};
      spec_st[ST_INF]  = 1'b1;
      spec_st[ST_DIVZ] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_z           = {sgn, 31'd0};
      spec_st[ST_ZERO] = 1'b1;
    end else begin
      spec = 1'b0;
    end
  end

  // ---- stage p1: classification and exponent registered at end of PREP ----
  always_ff @(posedge clk) begin
    if (load) begin
      sgn_p1     <= sgn;
      exp_p1     <= exp_adj;
      spec_p1    <= spec;
      spec_z_p1  <= spec_z;
      spec_st_p1 <= spec_st;
    end
  end

  // Round the quotient, then resolve overflow, underflow and special overrides.
  always_comb begin
    up      = round_up(rnd_p0, sgn_p1, quot[1], quot[0], sticky);
    inexact = quot[0] | sticky;
    mant_r  = {1'b0, quot[QBITS-1:1]} + {24'd0, up};
    exp_r   = exp_p1 + (mant_r[24] ? 10'sd1 : 10'sd0);
    z_nx    = '0;
    st_nx   = '0;
    if (spec_p1) begin
      z_nx  = spec_z_p1;
      st_nx = spec_st_p1;
    end else if (exp_r > 10'sd254) begin
      z_nx               = ovf_result(rnd_p0, sgn_p1);
      st_nx[ST_HUGE]     = 1'b1;
      st_nx[ST_INEXACT]  = 1'b1;
      st_nx[ST_INF]      = (z_nx[30:0] == POS_INF[30:0]);
    end else if ((exp_r < 10'sd1) || !(mant_r[24] | mant_r[23])) begin
      // A quotient without its leading one cannot be packed; treat it as underflow.
      z_nx               = {sgn_p1, 31'd0};
      st_nx[ST_TINY]     = 1'b1;
      st_nx[ST_INEXACT]  = 1'b1;
      st_nx[ST_ZERO]     = 1'b1;
    end else begin
      z_nx               = {sgn_p1, exp_r[7:0], mant_r[22:0]};
      st_nx[ST_INEXACT]  = inexact;
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  rnd = '0;
  logic        busy, done;
  logic [31:0] z;
  logic [7:0]  status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div_iter #(.QBITS(25)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .rnd    (rnd),
    .busy   (busy),
    .done   (done),
    .z      (z),
    .status (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient, rounding table, then exception rules.
  function automatic logic [39:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] m);
    logic s, xz, yz, xi, yi, xn, yn, g, st, up, to_inf;
    int ex, ey, e;
    longint unsigned mx, my, num, q, r, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {8'h04, 32'h7FC00000};
    if (xi) return {8'h02, s, 31'h7F800000};
    if (yz) return {8'h42, s, 31'h7F800000};
    if (xz || yi) return {8'h01, s, 31'd0};
    mx = 64'(x[22:0]) + 64'h800000;
    my = 64'(y[22:0]) + 64'h800000;
    e  = ex - ey + 127;
    if (mx < my) begin
      e   = e - 1;
      num = mx << 25;
    end else begin
      num = mx << 24;
    end
    q    = num / my;
    r    = num % my;
    mant = q >> 1;
    g    = q[0];
    st   = (r != 0);
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = (g | st) & ~s;
      3'd3:    up = (g | st) & s;
      3'd4:    up = g;
      3'd5:    up = g | st;
      default: up = g & (mant[0] | st);
    endcase
    mant = mant + 64'(up);
    if (mant == 64'h1000000) begin
      mant = 64'h800000;
      e    = e + 1;
    end
    if (e > 254) begin
      to_inf = (m == 3'd1) ? 1'b0 : (m == 3'd2) ? ~s : (m == 3'd3) ? s : 1'b1;
      return to_inf ? {8'h32, s, 31'h7F800000} : {8'h30, s, 31'h7F7FFFFF};
    end
    if (e < 1) return {8'h29, s, 31'd0};
    return {((g | st) ? 8'h20 : 8'h00), s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    logic [7:0]  e;
    logic [22:0] f;
    sel = int'($urandom_range(0, 11));
    f   = 23'($urandom);
    case (sel)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
      2:       e = 8'hFE;
      3:       e = 8'h01;
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // One full transaction; returns edges from start to done and busy-cycle count.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] tr,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb_v; rnd = tr; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = int'(busy);
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      bcnt += int'(busy);
    end
  endtask

  initial begin
    int lat, bcnt, n;
    logic [31:0] ra, rb;
    logic [2:0]  rr;
    logic [39:0] exp_v;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 6 / 2
    run_op(32'h40C00000, 32'h40000000, 3'd0, lat, bcnt);
    chk("six_two_lat", 32'(lat), 32'd27);
    chk("six_two_busy", 32'(bcnt), 32'd26);
    chk("six_two_z", z, 32'h40400000);
    chk("six_two_st", 32'(status), 32'h00);

    // 1 / 3 in two modes
    run_op(32'h3F800000, 32'h40400000, 3'd0, lat, bcnt);
    chk("third_near_z", z, 32'h3EAAAAAB);
    chk("third_near_st", 32'(status), 32'h20);
    run_op(32'h3F800000, 32'h40400000, 3'd1, lat, bcnt);
    chk("third_zero_z", z, 32'h3EAAAAAA);
    chk("third_zero_st", 32'(status), 32'h20);

    // Division by zero and 0/0
    run_op(32'h3F800000, 32'h00000000, 3'd0, lat, bcnt);
    chk("divz_z", z, 32'h7F800000);
    chk("divz_st", 32'(status), 32'h42);
    run_op(32'h00000000, 32'h00000000, 3'd0, lat, bcnt);
    chk("zz_z", z, 32'h7FC00000);
    chk("zz_st", 32'(status), 32'h04);

    // Overflow under several modes
    run_op(32'h7F7FFFFF, 32'h3F000000, 3'd0, lat, bcnt);
    chk("ovf_near_z", z, 32'h7F800000);
    chk("ovf_near_st", 32'(status), 32'h32);
    run_op(32'h7F7FFFFF, 32'h3F000000, 3'd1, lat, bcnt);
    chk("ovf_zero_z", z, 32'h7F7FFFFF);
    chk("ovf_zero_st", 32'(status), 32'h30);
    run_op(32'h7F7FFFFF, 32'h3F000000, 3'd3, lat, bcnt);
    chk("ovf_ninf_z", z, 32'h7F7FFFFF);

    // Underflow
    run_op(32'h00800000, 32'h40000000, 3'd0, lat, bcnt);
    chk("unf_z", z, 32'h00000000);
    chk("unf_st", 32'(status), 32'h29);

    // start while busy is ignored
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rnd = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    chk("ign_busy_seen", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin @(posedge clk); #1; n++; end
    chk("ign_done_seen", 32'(done), 32'd1);
    chk("ign_z", z, 32'h40400000);
    chk("ign_st", 32'(status), 32'h00);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; rnd = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_z", z, 32'd0);
    chk("mid_rst_st", 32'(status), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h3F800000, 32'h40400000, 3'd0, lat, bcnt);
    chk("post_rst_lat", 32'(lat), 32'd27);
    chk("post_rst_z", z, 32'h3EAAAAAB);
    chk("post_rst_st", 32'(status), 32'h20);

    // Randomised operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra    = rand_op();
      rb    = rand_op();
      rr    = 3'($urandom_range(0, 7));
      exp_v = ref_div(ra, rb, rr);
      run_op(ra, rb, rr, lat, bcnt);
      chk($sformatf("rand%0d_z a=%h b=%h m=%0d", i, ra, rb, rr), z, exp_v[31:0]);
      chk($sformatf("rand%0d_st", i), 32'(status), 32'(exp_v[39:32]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative IEEE 754 single-precision divider, z = a / b. It is the inverse-operation companion of the team's combinational FP multiplier.
- Uses the same rounding-mode encoding, the same denormal flush policy and the same 8-bit status layout as the multiplier.
- Computes the quotient mantissa with a radix-2 restoring loop behind a start/busy/done handshake, so it sits as a multi-cycle unit in the FP datapath.

Parameters:
- QBITS, 25, quotient bits generated (24 significand bits + 1 guard bit). Fixed; it is exposed only for the bench.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  32  dividend; captured on the accepted start.
- b  in  32  divisor; captured on the accepted start.
- rnd  in  3  rounding mode; captured on the accepted start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- z  out  32  result; held until the next completion.
- status  out  8  flags; held with z.

Behaviour:
- Reset (rst low, any time, including mid-operation):
  - state goes to IDLE; busy=0, done=0, z=0, status=0.
  - The operation in flight is discarded.
- States and transitions:
  - IDLE: on start=1, capture a, b, rnd -> PREP.
  - PREP (1 cycle): unpack, classify, pre-normalise -> DIV.
  - DIV (exactly 25 cycles, cnt 0..24) -> RND.
  - RND (1 cycle): round, handle exceptions, register z and status, pulse done -> IDLE.
- Latency:
  - Fixed at 27 edges. If start is sampled at edge T, z, status and done update at edge T+27.
  - Special operands still traverse all states; the result is overridden in RND.
  - start while busy is ignored. start in the done cycle is accepted, because the state is then IDLE.
- Unpack and classify:
  - Exponent 0 counts as zero, so denormal inputs flush to zero.
  - Significand = {1, frac}.
  - Sign = a[31] ^ b[31].
- Exponent:
  - Signed 10-bit: e = ea - eb + 127.
  - If ma < mb, ma is shifted left 1 and e is decremented, so the quotient lies in [1,2).
- Divide:
  - Restoring division, one quotient bit per cycle, MSB first, 25 bits total.
  - Guard G = q[0]; mantissa = q[24:1]; sticky S = (final remainder != 0).
- Rounding, with L = mantissa LSB:
  - IEEE_near (0): up if G&(L|S).
  - IEEE_zero (1): never rounds up.
  - IEEE_pinf (2): up if (G|S)&~sign.
  - IEEE_ninf (3): up if (G|S)&sign.
  - near_up (4): up if G.
  - away_zero (5): up if G|S.
  - Codes 6 and 7 behave as IEEE_near.
  - inexact = G|S.
  - A carry out to 2.0 increments e and the mantissa becomes 1.0.
- Overflow (post-round e > 254):
  - huge=1, inexact=1.
  - Result is ±inf for modes 0, 4 and 5.
  - Result is ±max-normal (0x7F7FFFFF with the sign applied) for mode 1.
  - Mode 2: +inf if positive, -max if negative. Mode 3: -inf if negative, +max if positive.
- Underflow (post-round e < 1): result is signed zero; tiny=1, inexact=1.
- Specials (these override and clear G/S-derived flags):
  - NaN operand, 0/0 or inf/inf -> 0x7FC00000 with nan=1.
  - inf/finite or nonzero/0 -> signed inf with inf=1. Nonzero/0 also sets divz=1.
  - 0/nonzero or finite/inf -> signed zero.
- status layout:
  - {1'b0, divz, inexact, huge, tiny, nan, inf, zero}.
  - zero=1 whenever z is ±0; inf=1 whenever z is ±inf.

Decomposition:
- Shared package fp_pkg:
  - rounding-mode constants (the existing codes 0..5);
  - status bit indices;
  - BIAS=127, CANON_NAN=0x7FC00000, MAX_NORMAL=0x7F7FFFFF;
  - state enum {IDLE, PREP, DIV, RND}.
- Sub-module fp_div_core: the 24-bit restoring mantissa divider.
  - Inputs: load, dividend, divisor. Output: 25-bit quotient, sticky.
  - The top level keeps the FSM, the exponent path, rounding and exceptions.

Test Plan:
- 0x40C00000 / 0x40000000, rnd=0 -> z=0x40400000, status=0x00; done exactly 27 edges after start; busy high for 26 cycles.
- 0x3F800000 / 0x40400000: rnd=0 -> z=0x3EAAAAAB, status=0x20; rnd=1 -> z=0x3EAAAAAA, status=0x20.
- 0x3F800000 / 0x00000000 -> z=0x7F800000, status=0x42. 0x00000000 / 0x00000000 -> z=0x7FC00000, status=0x04.
- 0x7F7FFFFF / 0x3F000000: rnd=0 -> z=0x7F800000, status=0x32; rnd=1 -> z=0x7F7FFFFF, status=0x30; rnd=3 -> z=0x7F7FFFFF.
- 0x00800000 / 0x40000000, rnd=0 -> z=0x00000000, status=0x29.
- Pulse start again at busy+5 with different operands -> it is ignored and the first result appears. Assert rst low at busy+10 -> busy, done, z and status are 0 immediately, and the next start gives the full 27-cycle latency.
